// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants for the CPU front end.
// No logic; enums, widths and default reset vector only.
// Imported by ifetch_unit and npc_calc.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam int IMM_W  = 16;

    localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Next-PC calculator: pc+4 or pc+4+sext(imm16)<<2, selected by npc_sel.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when npc is consumed.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [IMM_W-1:0]  imm16,
    input  logic              npc_sel,
    output logic [WORD_W-1:0] npc
);

    logic [WORD_W-1:0] seq;
    logic [WORD_W-1:0] offset;

    // Sequential and branch targets; both wrap modulo 2^32.
    always_comb begin
        seq    = pc + 32'd4;
        offset = {{14{imm16[IMM_W-1]}}, imm16, 2'b00};
        npc    = npc_sel ? (seq + offset) : seq;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: holds pc, fetches from variable-latency imem, commits next pc.
// Latency: inst_valid one cycle after imem_ready; one instruction per fetch latency + 1 + stall cycles.
// Backpressure: stall holds inst/pc/count in EXEC; request held stable until imem_ready.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int                MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              npc_sel,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [WORD_W-1:0] inst,
    output logic              inst_valid,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instr_count,
    output logic              fetch_err
);

    localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              imem_req_q, imem_req_d;
    logic [WORD_W-1:0] instr_count_q, instr_count_d;
    logic              fetch_err_q, fetch_err_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [WORD_W-1:0] npc;

    npc_calc u_npc_calc (
        .pc      (pc_q),
        .imm16   (inst_q[IMM_W-1:0]),
        .npc_sel (npc_sel),
        .npc     (npc)
    );

    // Next-state and datapath updates for the BOOT/FETCH/EXEC sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_valid_d  = inst_valid_q;
        imem_req_d    = imem_req_q;
        instr_count_d = instr_count_q;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    wait_cnt_d   = 16'd0;
                    imem_req_d   = 1'b0;
                    state_d      = ST_EXEC;
                end else if (wait_cnt_q < MAX_W) begin
                    // Saturating watchdog; the flag is sticky, the request keeps going.
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_q == MAX_W - 16'd1) begin
                        fetch_err_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // npc is only consumed on a non-stalled edge, so npc_sel is
                // effectively re-evaluated at the real commit.
                if (!stall) begin
                    pc_d          = npc;
                    inst_valid_d  = 1'b0;
                    instr_count_d = instr_count_q + 32'd1;
                    imem_req_d    = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // All fetch-stage state; reset aborts any fetch or stall immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            inst_valid_q  <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_count_q <= '0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_valid_q  <= inst_valid_d;
            imem_req_q    <= imem_req_d;
            instr_count_q <= instr_count_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign pc          = pc_q;
    assign instr_count = instr_count_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        npc_sel;
    logic [31:0] rdata;
    logic        ready;

    logic        req_a, vld_a, err_a;
    logic [31:0] addr_a, inst_a, pc_a, cnt_a;
    logic        req_b, vld_b, err_b;
    logic [31:0] addr_b, inst_b, pc_b, cnt_b;
    logic        req_c, vld_c, err_c;
    logic [31:0] addr_c, inst_c, pc_c, cnt_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifetch_unit dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .npc_sel(npc_sel),
        .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata), .imem_ready(ready),
        .inst(inst_a), .inst_valid(vld_a), .pc(pc_a), .instr_count(cnt_a), .fetch_err(err_a)
    );

    ifetch_unit #(.MAX_WAIT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .npc_sel(npc_sel),
        .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata), .imem_ready(ready),
        .inst(inst_b), .inst_valid(vld_b), .pc(pc_b), .instr_count(cnt_b), .fetch_err(err_b)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_c (
        .clk(clk), .rst_n(rst_n), .stall(stall), .npc_sel(npc_sel),
        .imem_req(req_c), .imem_addr(addr_c), .imem_rdata(rdata), .imem_ready(ready),
        .inst(inst_c), .inst_valid(vld_c), .pc(pc_c), .instr_count(cnt_c), .fetch_err(err_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; stall = 1'b0; npc_sel = 1'b0; ready = 1'b0; rdata = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (req_a !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", req_a); end
        checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", vld_a); end
        checks++; if (pc_a !== 32'h0040_0000) begin failures++; $display("FAIL rst_pc got=%h exp=00400000", pc_a); end
        checks++; if (inst_a !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst_a); end
        checks++; if (cnt_a !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", cnt_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_a); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (req_a !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", req_a); end
        tick();
        checks++; if (req_a !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", req_a); end
        checks++; if (addr_a !== 32'h0040_0000) begin failures++; $display("FAIL first_addr got=%h exp=00400000", addr_a); end
        repeat (3) tick();
        checks++; if (req_a !== 1'b1) begin failures++; $display("FAIL wait_req got=%b exp=1", req_a); end
        // Asynchronous abort mid-fetch.
        rst_n = 1'b0;
        #1;
        checks++; if (req_a !== 1'b0) begin failures++; $display("FAIL abort_req got=%b exp=0", req_a); end
        checks++; if (pc_a !== 32'h0040_0000) begin failures++; $display("FAIL abort_pc got=%h exp=00400000", pc_a); end
        tick();
        rst_n = 1'b1;
        checks++; if (req_a !== 1'b0) begin failures++; $display("FAIL reboot_req got=%b exp=0", req_a); end
        tick();
        checks++; if (req_a !== 1'b1 || addr_a !== 32'h0040_0000) begin failures++; $display("FAIL refetch got req=%b addr=%h exp req=1 addr=00400000", req_a, addr_a); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'h0040_0000 + 32'(4 * i);
            checks++; if (req_a !== 1'b1 || addr_a !== exp_addr) begin failures++; $display("FAIL seq_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, req_a, addr_a, exp_addr); end
            ready = 1'b1;
            rdata = 32'h1234_0000 + 32'(i);
            tick();
            checks++; if (vld_a !== 1'b1 || req_a !== 1'b0 || inst_a !== 32'h1234_0000 + 32'(i)) begin failures++; $display("FAIL seq_exec%0d got vld=%b req=%b inst=%h exp vld=1 req=0 inst=%h", i, vld_a, req_a, inst_a, 32'h1234_0000 + 32'(i)); end
            tick();
        end
        checks++; if (cnt_a !== 32'd3) begin failures++; $display("FAIL seq_count got=%0d exp=3", cnt_a); end
        checks++; if (pc_a !== 32'h0040_000C) begin failures++; $display("FAIL seq_pc got=%h exp=0040000C", pc_a); end
        tick();
        tick();
        checks++; if (pc_a !== 32'h0040_0010) begin failures++; $display("FAIL seq_pc4 got=%h exp=00400010", pc_a); end
    endtask

    task automatic test_branch();
        logic [15:0] imm [4];
        logic [31:0] exp [4];
        imm[0] = 16'hFFFF; exp[0] = 32'h0040_0010;
        imm[1] = 16'h8000; exp[1] = 32'h003E_0014;
        imm[2] = 16'h7FFE; exp[2] = 32'h0040_0010;
        imm[3] = 16'h0003; exp[3] = 32'h0040_0020;
        for (int k = 0; k < 4; k++) begin
            ready = 1'b1;
            rdata = {16'h1000, imm[k]};
            npc_sel = 1'b0;
            tick();
            npc_sel = 1'b1;
            tick();
            npc_sel = 1'b0;
            checks++; if (addr_a !== exp[k]) begin failures++; $display("FAIL branch_%h got=%h exp=%h", imm[k], addr_a, exp[k]); end
        end
        checks++; if (cnt_a !== 32'd8) begin failures++; $display("FAIL branch_count got=%0d exp=8", cnt_a); end
    endtask

    task automatic test_stall();
        ready = 1'b1;
        rdata = 32'hCAFE_0001;
        tick();
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            npc_sel = (j % 2 == 0);
            rdata = 32'hDEAD_0000 + 32'(j);
            tick();
            checks++; if (vld_a !== 1'b1 || req_a !== 1'b0 || inst_a !== 32'hCAFE_0001 || pc_a !== 32'h0040_0020 || cnt_a !== 32'd8) begin
                failures++; $display("FAIL stall_hold%0d got vld=%b req=%b inst=%h pc=%h cnt=%0d exp vld=1 req=0 inst=CAFE0001 pc=00400020 cnt=8", j, vld_a, req_a, inst_a, pc_a, cnt_a);
            end
        end
        stall = 1'b0;
        npc_sel = 1'b0;
        tick();
        checks++; if (pc_a !== 32'h0040_0024 || req_a !== 1'b1 || vld_a !== 1'b0 || cnt_a !== 32'd9) begin
            failures++; $display("FAIL stall_release got pc=%h req=%b vld=%b cnt=%0d exp pc=00400024 req=1 vld=0 cnt=9", pc_a, req_a, vld_a, cnt_a);
        end
    endtask

    task automatic test_wait_states();
        ready = 1'b0;
        rdata = 32'h5555_AAAA;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (req_a !== 1'b1 || addr_a !== 32'h0040_0024 || vld_a !== 1'b0) begin failures++; $display("FAIL wait_hold%0d got req=%b addr=%h vld=%b exp req=1 addr=00400024 vld=0", j, req_a, addr_a, vld_a); end
        end
        ready = 1'b1;
        tick();
        checks++; if (vld_a !== 1'b1 || inst_a !== 32'h5555_AAAA) begin failures++; $display("FAIL wait_done got vld=%b inst=%h exp vld=1 inst=5555AAAA", vld_a, inst_a); end
        checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin failures++; $display("FAIL wait_err got a=%b b=%b exp 0 0", err_a, err_b); end
        tick();
        checks++; if (pc_a !== 32'h0040_0028) begin failures++; $display("FAIL wait_commit got=%h exp=00400028", pc_a); end
    endtask

    task automatic test_timeout();
        ready = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 7) begin
                checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", err_b); end
            end
            if (j == 8) begin
                checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL tmo_set got=%b exp=1", err_b); end
            end
        end
        checks++; if (err_a !== 1'b0 || req_b !== 1'b1) begin failures++; $display("FAIL tmo_other got err_a=%b req_b=%b exp 0 1", err_a, req_b); end
        ready = 1'b1;
        rdata = 32'h0BAD_F00D;
        tick();
        checks++; if (vld_b !== 1'b1 || inst_b !== 32'h0BAD_F00D || err_b !== 1'b1) begin failures++; $display("FAIL tmo_late got vld=%b inst=%h err=%b exp 1 0BADF00D 1", vld_b, inst_b, err_b); end
        ready = 1'b0;
        tick();
        checks++; if (pc_b !== 32'h0040_002C || err_b !== 1'b1 || cnt_b !== 32'd11) begin failures++; $display("FAIL tmo_commit got pc=%h err=%b cnt=%0d exp 0040002C 1 11", pc_b, err_b, cnt_b); end
        checks++; if (cnt_a !== 32'd11) begin failures++; $display("FAIL tmo_cnt_a got=%0d exp=11", cnt_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (err_b !== 1'b0 || cnt_b !== 32'd0) begin failures++; $display("FAIL tmo_clear got err=%b cnt=%0d exp 0 0", err_b, cnt_b); end
    endtask

    task automatic test_wrap();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (req_c !== 1'b1 || addr_c !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got req=%b addr=%h exp 1 FFFFFFFC", req_c, addr_c); end
        ready = 1'b1;
        npc_sel = 1'b0;
        rdata = 32'h0000_0010;
        tick();
        tick();
        checks++; if (req_c !== 1'b1 || addr_c !== 32'h0000_0000 || cnt_c !== 32'd1) begin failures++; $display("FAIL wrap_second got req=%b addr=%h cnt=%0d exp 1 00000000 1", req_c, addr_c, cnt_c); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wait_states();
        test_timeout();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
